// File: rtl/distortion_fx_if.sv
// Sample-stream and static-configuration bundle for the distortion stage.
// The master drives samples and settings; the slave returns the shaped stream.
interface distortion_fx_if #(
  parameter int WIDTH  = 16,
  parameter int GAIN_W = 8,
  parameter int HOLD_W = 4
);
  logic                       in_valid;
  logic signed [WIDTH-1:0]    in_data;
  logic [1:0]                 mode;
  logic [GAIN_W-1:0]          gain;
  logic [WIDTH-2:0]           thresh;
  logic [$clog2(WIDTH)-1:0]   crush_bits;
  logic [HOLD_W-1:0]          hold;
  logic                       out_valid;
  logic signed [WIDTH-1:0]    out_data;
  logic                       clip_flag;

  modport master (
    output in_valid, in_data, mode, gain, thresh, crush_bits, hold,
    input  out_valid, out_data, clip_flag
  );

  modport slave (
    input  in_valid, in_data, mode, gain, thresh, crush_bits, hold,
    output out_valid, out_data, clip_flag
  );
endinterface

// File: rtl/distortion_fx.sv
// Three-stage multi-mode distortion: gain with saturation, waveshaping
// (bypass / hard clip / soft clip / bit-crush), then decimating output register.
module distortion_fx #(
  parameter int WIDTH     = 16,
  parameter int GAIN_W    = 8,
  parameter int GAIN_FRAC = 4,
  parameter int HOLD_W    = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  distortion_fx_if.slave bus
);
  localparam int CB_W = $clog2(WIDTH);
  localparam int PW   = WIDTH + GAIN_W + 1;
  localparam logic signed [WIDTH-1:0] S_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] S_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    MODE_BYPASS = 2'd0,
    MODE_HARD   = 2'd1,
    MODE_SOFT   = 2'd2,
    MODE_CRUSH  = 2'd3
  } mode_e;

  // ---------------- S1: gain and saturation ----------------
  logic signed [PW-1:0]    din_ext, gain_ext, prod, scaled;
  logic [PW-WIDTH:0]       top_bits;
  logic signed [WIDTH-1:0] g_next;
  logic                    sat_next;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    din_ext  = PW'(bus.in_data);
    gain_ext = $signed({{(PW-GAIN_W){1'b0}}, bus.gain});
    prod     = din_ext * gain_ext;
    scaled   = prod >>> GAIN_FRAC;
    top_bits = scaled[PW-1:WIDTH-1];
    g_next   = scaled[WIDTH-1:0];
    sat_next = 1'b0;
    if (mode_e'(bus.mode) == MODE_BYPASS) begin
      g_next = bus.in_data;
    end else if (!(&top_bits) && (|top_bits)) begin
      sat_next = 1'b1;
      g_next   = scaled[PW-1] ? S_MIN : S_MAX;
    end
  end

  logic                    v1, sat1;
  logic signed [WIDTH-1:0] g1;
  mode_e                   mode1;
  logic [WIDTH-2:0]        thresh1;
  logic [CB_W-1:0]         crush1;
  logic [HOLD_W-1:0]       hold1;

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1      <= 1'b0;
      sat1    <= 1'b0;
      g1      <= '0;
      mode1   <= MODE_BYPASS;
      thresh1 <= '0;
      crush1  <= '0;
      hold1   <= '0;
    end else begin
      v1 <= bus.in_valid;
      if (bus.in_valid) begin
        sat1    <= sat_next;
        g1      <= g_next;
        mode1   <= mode_e'(bus.mode);
        thresh1 <= bus.thresh;
        crush1  <= bus.crush_bits;
        hold1   <= bus.hold;
      end
    end
  end

  // ---------------- S2: waveshaping ----------------
  logic [WIDTH:0]          g_wide, mag, t_ext, lim_mag, sgn_mag;
  logic                    neg, over, clip_next;
  logic signed [WIDTH-1:0] y_next;

  // Magnitude is one bit wider so the most negative sample has a representable |g|.
  always_comb begin
    g_wide  = {g1[WIDTH-1], g1};
    neg     = g1[WIDTH-1];
    mag     = neg ? -g_wide : g_wide;
    t_ext   = {2'b00, thresh1};
    over    = mag > t_ext;
    lim_mag = t_ext;
    if (mode1 == MODE_SOFT) lim_mag = t_ext + ((mag - t_ext) >> 2);
    sgn_mag   = neg ? -lim_mag : lim_mag;
    y_next    = g1;
    clip_next = 1'b0;
    case (mode1)
      MODE_HARD, MODE_SOFT: begin
        if (over) begin
          y_next    = sgn_mag[WIDTH-1:0];
          clip_next = 1'b1;
        end
      end
      MODE_CRUSH: y_next = g1 & ({WIDTH{1'b1}} << crush1);
      default: ;
    endcase
  end

  logic                    v2, flag2;
  logic signed [WIDTH-1:0] y2;
  mode_e                   mode2;
  logic [HOLD_W-1:0]       hold2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2    <= 1'b0;
      flag2 <= 1'b0;
      y2    <= '0;
      mode2 <= MODE_BYPASS;
      hold2 <= '0;
    end else begin
      v2 <= v1;
      if (v1) begin
        flag2 <= sat1 | clip_next;
        y2    <= y_next;
        mode2 <= mode1;
        hold2 <= hold1;
      end
    end
  end

  // ---------------- S3: decimation and output ----------------
  logic [HOLD_W-1:0]       cnt, last_hold, eff_cnt, cnt_inc;
  logic signed [WIDTH-1:0] held, out_data_q;
  logic                    held_flag, out_valid_q, clip_q;

  // A change of hold factor restarts decimation with a fresh capture.
  always_comb begin
    eff_cnt = (hold2 != last_hold) ? '0 : cnt;
    cnt_inc = eff_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      last_hold   <= '0;
      held        <= '0;
      held_flag   <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      clip_q      <= 1'b0;
    end else begin
      out_valid_q <= v2;
      if (v2) begin
        last_hold <= hold2;
        if (mode2 != MODE_CRUSH) begin
          cnt        <= '0;
          out_data_q <= y2;
          clip_q     <= flag2;
        end else if (eff_cnt == '0) begin
          held       <= y2;
          held_flag  <= flag2;
          out_data_q <= y2;
          clip_q     <= flag2;
          cnt        <= (hold2 <= HOLD_W'(1)) ? '0 : HOLD_W'(1);
        end else begin
          out_data_q <= held;
          clip_q     <= held_flag;
          cnt        <= (cnt_inc == hold2) ? '0 : cnt_inc;
        end
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.clip_flag = clip_q;
endmodule
